// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong frame constants, decoded game state and receiver FSM state types
package pong_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam int         FRAME_LEN = 9;

    localparam logic [3:0] IDX_P1   = 4'd1;
    localparam logic [3:0] IDX_P2   = 4'd2;
    localparam logic [3:0] IDX_BX_M = 4'd3;
    localparam logic [3:0] IDX_BX_L = 4'd4;
    localparam logic [3:0] IDX_BY_M = 4'd5;
    localparam logic [3:0] IDX_BY_L = 4'd6;
    localparam logic [3:0] IDX_SC1  = 4'd7;
    localparam logic [3:0] IDX_SC2  = 4'(FRAME_LEN - 1);

    localparam int FIELD_W = 400;
    localparam int FIELD_H = 256;

    typedef struct packed {
        logic [7:0] p1;
        logic [7:0] p2;
        logic [8:0] bx;
        logic [8:0] by;
        logic [7:0] score1;
        logic [7:0] score2;
    } pong_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic {
        F_HUNT,
        F_COLLECT
    } frame_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: rx synchroniser, oversample tick divider and byte FSM
module uart_rx_byte
    import pong_pkg::*;
#(
    parameter int CLK_DIV_COUNT = 27,
    parameter int OSF           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int DIV_W  = (CLK_DIV_COUNT > 1) ? $clog2(CLK_DIV_COUNT) : 1;
    localparam int TICK_W = $clog2(OSF);

    logic              rx_meta_q, rx_s_q;
    logic [DIV_W-1:0]  div_q;
    logic              tick;
    rx_state_e         state_q, state_d;
    logic [TICK_W-1:0] tcnt_q, tcnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    // Free-running divider: the tick is never re-aligned to the start edge.
    assign tick = (div_q == DIV_W'(CLK_DIV_COUNT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            div_q     <= '0;
            state_q   <= RX_IDLE;
            tcnt_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            div_q     <= tick ? '0 : div_q + 1'b1;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (tick && !rx_s_q) begin
                    tcnt_d  = '0;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tcnt_q == TICK_W'(OSF / 2 - 1)) begin
                        tcnt_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? RX_IDLE : RX_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tcnt_q == TICK_W'(OSF - 1)) begin
                        tcnt_d  = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d = RX_STOP;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (tcnt_q == TICK_W'(OSF - 1)) begin
                        tcnt_d = '0;
                        if (rx_s_q) begin
                            valid_d = 1'b1;
                            state_d = RX_IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = RX_WAIT_HIGH;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data       = shift_q;
    assign byte_valid = valid_q;
    assign byte_err   = err_q;

endmodule

// File: rtl/pong_frame_rx.sv
// rtl/pong_frame_rx.sv - pong frame receiver: sync hunt, 9-byte collect, atomic state update; PONG_RX_TIMEOUT_EN adds inter-byte timeout
module pong_frame_rx
    import pong_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int OSF         = 16,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  p1,
    output logic [7:0]  p2,
    output logic [8:0]  bx,
    output logic [8:0]  by,
    output logic [7:0]  score1,
    output logic [7:0]  score2,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int CLK_DIV_COUNT = CLK_FREQ / (OSF * BAUD);

    logic [7:0]   byte_data;
    logic         byte_valid, byte_err;

    frame_state_e fstate_q, fstate_d;
    logic [3:0]   idx_q, idx_d;
    pong_state_t  shadow_q, shadow_d;
    pong_state_t  state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         fvalid_q, fvalid_d;
    logic         ferr_q, ferr_d;
`ifdef PONG_RX_TIMEOUT_EN
    logic [31:0]  to_q, to_d;
`endif

    uart_rx_byte #(
        .CLK_DIV_COUNT(CLK_DIV_COUNT),
        .OSF          (OSF)
    ) u_rx_byte (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (byte_data),
        .byte_valid(byte_valid),
        .byte_err  (byte_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fstate_q <= F_HUNT;
            idx_q    <= '0;
            shadow_q <= '0;
            state_q  <= '0;
            cnt_q    <= '0;
            fvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef PONG_RX_TIMEOUT_EN
            to_q     <= '0;
`endif
        end else begin
            fstate_q <= fstate_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fvalid_q <= fvalid_d;
            ferr_q   <= ferr_d;
`ifdef PONG_RX_TIMEOUT_EN
            to_q     <= to_d;
`endif
        end
    end

    always_comb begin
        fstate_d = fstate_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        fvalid_d = 1'b0;
        ferr_d   = 1'b0;
`ifdef PONG_RX_TIMEOUT_EN
        to_d     = '0;
`endif
        case (fstate_q)
            F_HUNT: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    idx_d    = IDX_P1;
                    fstate_d = F_COLLECT;
                end
            end
            F_COLLECT: begin
                if (byte_err) begin
                    ferr_d   = 1'b1;
                    fstate_d = F_HUNT;
                end else if (byte_valid) begin
                    idx_d = idx_q + 4'd1;
                    case (idx_q)
                        IDX_P1:   shadow_d.p1 = byte_data;
                        IDX_P2:   shadow_d.p2 = byte_data;
                        IDX_BX_L: shadow_d.bx[7:0] = byte_data;
                        IDX_BY_L: shadow_d.by[7:0] = byte_data;
                        IDX_SC1:  shadow_d.score1 = byte_data;
                        IDX_BX_M, IDX_BY_M: begin
                            if (byte_data[7:1] != 7'd0) begin
                                ferr_d   = 1'b1;
                                fstate_d = F_HUNT;
                            end else if (idx_q == IDX_BX_M) begin
                                shadow_d.bx[8] = byte_data[0];
                            end else begin
                                shadow_d.by[8] = byte_data[0];
                            end
                        end
                        IDX_SC2: begin
                            // Last byte bypasses the shadow so every field lands in one edge.
                            state_d        = shadow_q;
                            state_d.score2 = byte_data;
                            cnt_d          = cnt_q + 16'd1;
                            fvalid_d       = 1'b1;
                            fstate_d       = F_HUNT;
                        end
                        default: fstate_d = F_HUNT;
                    endcase
                end
`ifdef PONG_RX_TIMEOUT_EN
                else if (to_q == 32'(TIMEOUT_CYC - 1)) begin
                    ferr_d   = 1'b1;
                    fstate_d = F_HUNT;
                end else begin
                    to_d = to_q + 32'd1;
                end
`endif
            end
            default: fstate_d = F_HUNT;
        endcase
    end

    assign p1          = state_q.p1;
    assign p2          = state_q.p2;
    assign bx          = state_q.bx;
    assign by          = state_q.by;
    assign score1      = state_q.score1;
    assign score2      = state_q.score2;
    assign frame_cnt   = cnt_q;
    assign frame_valid = fvalid_q;
    assign frame_err   = ferr_q;

endmodule

// File: doc/pong_frame_rx.md
Name: pong_frame_rx

Overview:
Receive-side counterpart of the pong UART frame transmitter. It deserialises 8N1 bytes at 115200 baud with 16x oversampling and hunts for the 0xAA sync byte. It collects the 9-byte frame (0xAA, p1, p2, bx_M, bx_L, by_M, by_L, score1, score2) and updates the decoded game state atomically with a one-cycle valid pulse. It is used for loopback/self-check and as the input stage of a second board mirroring the game.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115_200, line rate
OSF, 16, oversample factor; CLK_DIV_COUNT = CLK_FREQ/(OSF*BAUD) (integer division, 27 at defaults, bit = 432 cycles)
TIMEOUT_CYC, 100_000, inter-byte timeout in clk cycles (used only with PONG_RX_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx  in  1  serial input, idle high, asynchronous to clk
p1  out  8  left paddle Y
p2  out  8  right paddle Y
bx  out  9  ball X, {bx_M[0], bx_L}
by  out  9  ball Y, {by_M[0], by_L}
score1  out  8  player 1 score
score2  out  8  player 2 score
frame_valid  out  1  one-cycle pulse when all fields update
frame_err  out  1  one-cycle pulse on a discarded frame
frame_cnt  out  16  count of good frames, wraps 0xFFFF->0

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, synchroniser flops 1, both FSMs idle, divider 0. Reset mid-byte or mid-frame discards all partial data.
- rx passes through a 2-FF synchroniser (rx_s). The oversample tick pulses 1 cycle every CLK_DIV_COUNT cycles and free-runs.
- Byte FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on rx_s==0 at a tick, clear tick counter, go to START.
  - START: after OSF/2 ticks, sample rx_s. If 0, go to DATA. If 1 (glitch), return to IDLE with no output.
  - DATA: sample every OSF ticks, shift LSB first, 8 bits, then go to STOP.
  - STOP: after OSF ticks, sample rx_s. If 1, pulse byte_valid for 1 cycle with the byte and go to IDLE. If 0, pulse byte_err and go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE when rx_s==1. A stuck-low line yields exactly one byte_err.
- Frame FSM states: HUNT, COLLECT.
  - HUNT: a byte_valid with data==0xAA sets idx=1 and goes to COLLECT. Other bytes are silently dropped and do not assert frame_err.
  - COLLECT: each byte_valid writes shadow[idx] and increments idx. A payload byte of 0xAA is data, not a resync.
  - Bytes at idx 3 and 5 must have bits [7:1]==0. Otherwise pulse frame_err and go to HUNT.
  - A byte_err while in COLLECT pulses frame_err and goes to HUNT. A byte_err while in HUNT is ignored.
  - On idx==8 byte_valid: on the next clk, all six output fields and frame_cnt update together and frame_valid=1 for that cycle. Then go to HUNT.
- Latency: frame_valid is 2 cycles after the stop-bit sample of byte 8. Outputs hold their values between frames and never show partial frames.
- Simultaneous events: frame_valid and frame_err are never high in the same cycle.

Optional Feature:
PONG_RX_TIMEOUT_EN
- Defined: a counter runs in COLLECT and clears on each byte_valid. Reaching TIMEOUT_CYC pulses frame_err and returns to HUNT.
- Not defined: no counter and no timeout; COLLECT waits indefinitely. TIMEOUT_CYC is unused.

Decomposition:
- Package pong_pkg holds: SYNC_BYTE=8'hAA, FRAME_LEN=9, field index constants (IDX_P1..IDX_SC2), FIELD_W=400, FIELD_H=256, and typedef struct pong_state_t {p1, p2, bx[8:0], by[8:0], score1, score2}. It is shared with the transmitter.
- One sub-module, uart_rx_byte, contains the synchroniser, tick divider and byte FSM. Its outputs are data[7:0], byte_valid and byte_err. The frame FSM stays in pong_frame_rx.

Test Plan:
1. Bytes AA,10,20,01,2C,00,80,03,05 at 432 cycles/bit -> single frame_valid; p1=0x10, p2=0x20, bx=300, by=128, score1=3, score2=5, frame_cnt=1.
2. Garbage 13,55 then the frame from 1 with p1=0xAA -> exactly one frame_valid, p1=0xAA, no frame_err.
3. Frame from 1 with byte 3 = 0x02 -> frame_err pulse, outputs unchanged, frame_cnt unchanged; the next good frame is accepted.
4. Byte 4 sent with stop bit 0 -> frame_err; rx held low 5000 cycles -> exactly one frame_err total; the following good frame gives frame_valid.
5. rx low pulse of 100 cycles -> no byte_valid, no outputs change. Reset asserted after byte 5 of a frame -> outputs 0 and the remaining bytes produce no frame_valid.
6. With PONG_RX_TIMEOUT_EN: 150_000-cycle gap after byte 4 -> frame_err at TIMEOUT_CYC. Without it, the same gap followed by bytes 5-8 -> frame_valid.
